// File: rtl/pipeline_control.sv
// ============================================================================
// Module   : pipeline_control
// Purpose  : Five-stage pipeline stall/flush/redirect sequencing with a
//            memory-wait FSM and saturating performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic             dcache_resp,
    input  logic             br_taken_ex,
    input  logic [31:0]      br_target_ex,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             pc_redirect,
    output logic [31:0]      pc_redirect_addr,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN            = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT       = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT_REDIR = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] stall_q,  stall_d;
    logic [CNT_W-1:0] flush_q,  flush_d;

    logic w_istall;
    logic w_dstall;
    logic w_mem_wait;
    logic w_redir_now;
    logic w_pending;

    assign w_istall    = icache_read & ~icache_resp;
    assign w_dstall    = (dcache_read | dcache_write) & ~dcache_resp;
    assign w_mem_wait  = w_istall | w_dstall;
    assign w_redir_now = br_taken_ex & ~hazard_stall;
    assign w_pending   = (state_q == ST_MEM_WAIT_REDIR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            target_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    // Only the first redirect seen during a wait is latched; later ones are dropped.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_wait && w_redir_now) begin
                    state_d  = ST_MEM_WAIT_REDIR;
                    target_d = br_target_ex;
                end else if (w_mem_wait) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT_REDIR: begin
                if (!w_mem_wait) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A latched redirect outranks a hazard stall on the release cycle.
    always_comb begin
        load_pc          = 1'b0;
        load_if_id       = 1'b0;
        load_id_ex       = 1'b0;
        load_ex_mem      = 1'b0;
        load_mem_wb      = 1'b0;
        bubble_ex_mem    = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = '0;
        if (!rst || w_mem_wait) begin
            load_pc = 1'b0;
        end else if (w_pending || (!hazard_stall && br_taken_ex)) begin
            load_pc          = 1'b1;
            load_if_id       = 1'b1;
            load_id_ex       = 1'b1;
            load_ex_mem      = 1'b1;
            load_mem_wb      = 1'b1;
            flush_if_id      = 1'b1;
            flush_id_ex      = 1'b1;
            pc_redirect      = 1'b1;
            pc_redirect_addr = w_pending ? target_q : br_target_ex;
        end else if (hazard_stall) begin
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            bubble_ex_mem = 1'b1;
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((w_mem_wait || hazard_stall) && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (pc_redirect && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control.sv
// ============================================================================
// Module   : tb_pipeline_control
// Purpose  : Directed and randomized checking of pipeline_control against a
//            behavioural model; a 4-bit counter build covers saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall, icache_read, icache_resp;
    logic        dcache_read, dcache_write, dcache_resp;
    logic        br_taken_ex;
    logic [31:0] br_target_ex;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        bubble_ex_mem, flush_if_id, flush_id_ex, pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles, flush_count;

    logic        n_load_pc, n_load_if_id, n_load_id_ex, n_load_ex_mem, n_load_mem_wb;
    logic        n_bubble, n_flush_if_id, n_flush_id_ex, n_pc_redirect;
    logic [31:0] n_addr;
    logic [1:0]  n_state;
    logic [3:0]  n_stall, n_flush;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_pending;
    logic [31:0] m_target;
    bit          m_prev_wait;
    longint      m_raw_stall, m_raw_flush;
    bit          e_mw, e_red;

    always #5 clk = ~clk;

    pipeline_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
        .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_resp(dcache_resp),
        .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .bubble_ex_mem(bubble_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall),
        .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_resp(dcache_resp),
        .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
        .load_pc(n_load_pc), .load_if_id(n_load_if_id), .load_id_ex(n_load_id_ex),
        .load_ex_mem(n_load_ex_mem), .load_mem_wb(n_load_mem_wb),
        .bubble_ex_mem(n_bubble), .flush_if_id(n_flush_if_id), .flush_id_ex(n_flush_id_ex),
        .pc_redirect(n_pc_redirect), .pc_redirect_addr(n_addr),
        .ctrl_state(n_state), .stall_cycles(n_stall), .flush_count(n_flush)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit hz, input bit ir, input bit irsp,
                         input bit dr, input bit dw, input bit drsp,
                         input bit br, input logic [31:0] tgt);
        rst = r; hazard_stall = hz; icache_read = ir; icache_resp = irsp;
        dcache_read = dr; dcache_write = dw; dcache_resp = drsp;
        br_taken_ex = br; br_target_ex = tgt;
    endtask

    // One clock: check combinational outputs mid-cycle, then registered state after the edge.
    task automatic cycle();
        logic [4:0]  e_ld;
        logic        e_bub, e_fl;
        logic [31:0] e_addr;
        logic [1:0]  e_state;
        #4;
        e_mw  = (icache_read && !icache_resp) || ((dcache_read || dcache_write) && !dcache_resp);
        e_ld  = 5'b00000; e_bub = 1'b0; e_fl = 1'b0; e_red = 1'b0; e_addr = 32'h0;
        if (!rst || e_mw) begin
            e_ld = 5'b00000;
        end else if (m_pending) begin
            e_ld = 5'b11111; e_fl = 1'b1; e_red = 1'b1; e_addr = m_target;
        end else if (hazard_stall) begin
            e_ld = 5'b00011; e_bub = 1'b1;
        end else if (br_taken_ex) begin
            e_ld = 5'b11111; e_fl = 1'b1; e_red = 1'b1; e_addr = br_target_ex;
        end else begin
            e_ld = 5'b11111;
        end
        chk("loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, e_ld);
        chk("bubble", bubble_ex_mem, e_bub);
        chk("flushes", {flush_if_id, flush_id_ex}, {e_fl, e_fl});
        chk("pc_redirect", pc_redirect, e_red);
        chk("redirect_addr", pc_redirect_addr, e_addr);

        @(posedge clk);
        #1;
        if (!rst) begin
            m_pending = 0; m_target = 32'h0; m_prev_wait = 0;
            m_raw_stall = 0; m_raw_flush = 0;
        end else begin
            if (e_mw || hazard_stall) m_raw_stall++;
            if (e_red) m_raw_flush++;
            if (e_mw) begin
                if (!m_pending && br_taken_ex && !hazard_stall) begin
                    m_pending = 1; m_target = br_target_ex;
                end
            end else begin
                m_pending = 0;
            end
            m_prev_wait = e_mw;
        end
        e_state = m_pending ? 2'd2 : (m_prev_wait ? 2'd1 : 2'd0);
        chk("ctrl_state", ctrl_state, e_state);
        chk("stall_cycles", stall_cycles, m_raw_stall);
        chk("flush_count", flush_count, m_raw_flush);
        chk("stall_cycles_w4", n_stall, (m_raw_stall > 15) ? 15 : m_raw_stall);
        chk("flush_count_w4", n_flush, (m_raw_flush > 15) ? 15 : m_raw_flush);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle();
    endtask

    initial begin
        m_pending = 0; m_target = 32'h0; m_prev_wait = 0;
        m_raw_stall = 0; m_raw_flush = 0;

        // Reset with noisy inputs: outputs forced quiet
        drive(0, 1, 1, 0, 1, 0, 0, 1, 32'hDEAD_BEEF);
        cycle();
        chk("reset_state", ctrl_state, 2'd0);
        chk("reset_stall", stall_cycles, 32'd0);

        // Load-use hazard
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("loaduse_stall", stall_cycles, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle();

        // D-cache miss for 5 cycles, then response
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 0, 32'h0);
            cycle();
            chk("dmiss_state", ctrl_state, 2'd1);
        end
        chk("dmiss_stall", stall_cycles, 32'd5);
        drive(1, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        cycle();
        chk("dmiss_release_state", ctrl_state, 2'd0);

        // Redirect during I-miss: first target kept
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 1, 32'h0000_0060);
        cycle();
        chk("redir_wait_state", ctrl_state, 2'd2);
        drive(1, 0, 1, 0, 0, 0, 0, 1, 32'h0000_0080);
        cycle();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        cycle();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        #4;
        chk("redir_release_addr", pc_redirect_addr, 32'h0000_0060);
        #0 cycle();
        chk("redir_flush_count", flush_count, 32'd1);
        chk("redir_after_state", ctrl_state, 2'd0);

        // Pending redirect released while hazard is high still applies
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 1, 32'h0000_1234);
        cycle();
        drive(1, 1, 0, 0, 0, 1, 1, 0, 32'h0);
        cycle();
        chk("redir_over_hazard", flush_count, 32'd1);

        // Hazard with branch in the same cycle
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0400);
        cycle();
        chk("hazard_branch_state", ctrl_state, 2'd0);
        chk("hazard_branch_flush", flush_count, 32'd0);

        // Reset in the middle of MEM_WAIT_REDIR discards the redirect
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0044);
        cycle();
        chk("midreset_enter", ctrl_state, 2'd2);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("midreset_no_redirect", flush_count, 32'd0);
        chk("midreset_state", ctrl_state, 2'd0);

        // Saturation of the 4-bit build
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
            cycle();
        end
        chk("sat_w4", n_stall, 4'hF);
        chk("sat_w32", stall_cycles, 32'd20);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
